pipeline_hazard_ctrl: RTL and testbench

Sequencing controller for the 3-stage RV32I pipeline (fetch / decode-execute / memory-writeback). It drives the enables and flushes of the fetch-to-decode and execute-to-memory pipeline registers, and selects operand forwarding into execute. It also runs the data-memory request/acknowledge handshake with a bounded wait. The block sits beside the pipeline registers and observes the instructions held in the execute and memory stages.

---
 rtl/pipeline_hazard_ctrl.sv | 159 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Function : Stall, flush, forwarding and data-memory handshake control for
//            a 3-stage RV32I pipeline (fetch / decode-execute / mem-writeback).
// Revision : 1.0
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      instruction_execute,
    input  logic [31:0]      instruction_mem,
    input  logic             reg_wr_mem,
    input  logic             branch_taken_execute,
    input  logic             dmem_ack,
    output logic             pc_en,
    output logic             fd_en,
    output logic             fd_flush,
    output logic             em_en,
    output logic             em_flush,
    output logic             fwd_a,
    output logic             fwd_b,
    output logic             dmem_req,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t              state;
    logic [WAIT_W-1:0]   wait_cnt;

    logic [6:0] op_ex;
    logic [6:0] op_mem;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd_mem;
    logic       rs1_used;
    logic       rs2_used;
    logic       mem_is_load;
    logic       mem_access;
    logic       timeout_now;
    logic       freeze;
    logic       load_use;
    logic       fwd_a_raw;
    logic       fwd_b_raw;

    assign op_ex   = instruction_execute[6:0];
    assign op_mem  = instruction_mem[6:0];
    assign rs1     = instruction_execute[19:15];
    assign rs2     = instruction_execute[24:20];
    assign rd_mem  = instruction_mem[11:7];

    // Fields this block never looks at.
    logic unused_bits;
    assign unused_bits = ^{instruction_execute[31:25], instruction_execute[14:7],
                           instruction_mem[31:12]};

    assign rs1_used    = !(op_ex == OP_LUI || op_ex == OP_AUIPC || op_ex == OP_JAL);
    assign rs2_used    = (op_ex == OP_REG) || (op_ex == OP_STORE) || (op_ex == OP_BRANCH);
    assign mem_is_load = (op_mem == OP_LOAD);
    assign mem_access  = mem_is_load || (op_mem == OP_STORE);

    assign timeout_now = (state == MEM_WAIT) && (wait_cnt == WAIT_LAST);
    assign freeze      = mem_access && !dmem_ack && !timeout_now;

    assign load_use = mem_is_load && (rd_mem != 5'd0) &&
                      ((rs1_used && rd_mem == rs1) || (rs2_used && rd_mem == rs2));

    assign fwd_a_raw = reg_wr_mem && (rd_mem != 5'd0) && !mem_is_load && rs1_used && (rd_mem == rs1);
    assign fwd_b_raw = reg_wr_mem && (rd_mem != 5'd0) && !mem_is_load && rs2_used && (rd_mem == rs2);

    always_comb begin
        pc_en    = 1'b1;
        fd_en    = 1'b1;
        fd_flush = 1'b0;
        em_en    = 1'b1;
        em_flush = 1'b0;
        fwd_a    = fwd_a_raw;
        fwd_b    = fwd_b_raw;
        dmem_req = mem_access;
        if (reset) begin
            pc_en    = 1'b0;
            fd_en    = 1'b0;
            em_en    = 1'b0;
            fd_flush = 1'b1;
            em_flush = 1'b1;
            fwd_a    = 1'b0;
            fwd_b    = 1'b0;
            dmem_req = 1'b0;
        end else if (freeze) begin
            pc_en = 1'b0;
            fd_en = 1'b0;
            em_en = 1'b0;
        end else if (load_use) begin
            // One bubble into memory stage; the load moves on next cycle.
            pc_en    = 1'b0;
            fd_en    = 1'b0;
            em_flush = 1'b1;
        end else if (branch_taken_execute) begin
            fd_flush = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= RUN;
            wait_cnt     <= '0;
            mem_err      <= 1'b0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            case (state)
                RUN: begin
                    wait_cnt <= '0;
                    if (mem_access && !dmem_ack) begin
                        state <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                    if (dmem_ack) begin
                        state <= RUN;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state   <= RUN;
                        mem_err <= 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
            if (!pc_en && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (fd_flush && flush_count != '1) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Function : Directed and randomized checks of pipeline_hazard_ctrl against a
//            cycle-level reference model. Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_pipeline_hazard_ctrl;

    localparam int T    = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] LW5 = 32'h0000_a283;   // lw x5,0(x1)
    localparam logic [31:0] SW5 = 32'h0050_a023;   // sw x5,0(x1)

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   instruction_execute = NOP;
    logic [31:0]   instruction_mem = NOP;
    logic          reg_wr_mem = 1'b0;
    logic          branch_taken_execute = 1'b0;
    logic          dmem_ack = 1'b0;
    logic          pc_en, fd_en, fd_flush, em_en, em_flush;
    logic          fwd_a, fwd_b, dmem_req, mem_err;
    logic [CW-1:0] stall_cycles, flush_count;

    int tests = 0;
    int fails = 0;

    // Reference model: how long the current memory access has been stuck.
    int pending   = 0;
    bit err_m     = 0;
    int stalls_m  = 0;
    int flushes_m = 0;
    bit frozen_m  = 0;

    always #5 clock = ~clock;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset),
        .instruction_execute(instruction_execute), .instruction_mem(instruction_mem),
        .reg_wr_mem(reg_wr_mem), .branch_taken_execute(branch_taken_execute),
        .dmem_ack(dmem_ack), .pc_en(pc_en), .fd_en(fd_en), .fd_flush(fd_flush),
        .em_en(em_en), .em_flush(em_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .dmem_req(dmem_req), .mem_err(mem_err),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit uses_rs1(input logic [6:0] op);
        return !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
    endfunction

    function automatic bit uses_rs2(input logic [6:0] op);
        return op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011;
    endfunction

    task automatic step(input logic rst, input logic [31:0] ex, input logic [31:0] mem,
                        input logic rw, input logic br, input logic ack);
        logic [6:0] om, oe;
        logic [4:0] rd, r1, r2;
        bit macc, ld, lu, frz;
        bit e_pc, e_fd, e_fdf, e_em, e_emf, e_fa, e_fb, e_req;
        reset = rst; instruction_execute = ex; instruction_mem = mem;
        reg_wr_mem = rw; branch_taken_execute = br; dmem_ack = ack;
        om = mem[6:0]; oe = ex[6:0]; rd = mem[11:7]; r1 = ex[19:15]; r2 = ex[24:20];
        ld   = (om == 7'b0000011);
        macc = ld || (om == 7'b0100011);
        frz  = macc && !ack && (pending < T);
        lu   = ld && rd != 0 && ((uses_rs1(oe) && rd == r1) || (uses_rs2(oe) && rd == r2));
        e_fa = rw && rd != 0 && !ld && uses_rs1(oe) && rd == r1;
        e_fb = rw && rd != 0 && !ld && uses_rs2(oe) && rd == r2;
        e_req = macc;
        {e_pc, e_fd, e_fdf, e_em, e_emf} = 5'b11010;
        if (rst) begin
            {e_pc, e_fd, e_fdf, e_em, e_emf} = 5'b00101;
            e_fa = 0; e_fb = 0; e_req = 0;
        end else if (frz) begin
            {e_pc, e_fd, e_fdf, e_em, e_emf} = 5'b00000;
        end else if (lu) begin
            {e_pc, e_fd, e_fdf, e_em, e_emf} = 5'b00011;
        end else if (br) begin
            {e_pc, e_fd, e_fdf, e_em, e_emf} = 5'b11110;
        end
        frozen_m = !rst && frz;
        @(negedge clock);
        chk("pc_en", 32'(pc_en), 32'(e_pc));
        chk("fd_en", 32'(fd_en), 32'(e_fd));
        chk("fd_flush", 32'(fd_flush), 32'(e_fdf));
        chk("em_en", 32'(em_en), 32'(e_em));
        chk("em_flush", 32'(em_flush), 32'(e_emf));
        chk("fwd_a", 32'(fwd_a), 32'(e_fa));
        chk("fwd_b", 32'(fwd_b), 32'(e_fb));
        chk("dmem_req", 32'(dmem_req), 32'(e_req));
        chk("mem_err", 32'(mem_err), 32'(err_m));
        chk("stall_cycles", 32'(stall_cycles), 32'(stalls_m));
        chk("flush_count", 32'(flush_count), 32'(flushes_m));
        @(posedge clock);
        if (rst) begin
            pending = 0; err_m = 0; stalls_m = 0; flushes_m = 0;
        end else begin
            if (!e_pc && stalls_m < CMAX) stalls_m++;
            if (e_fdf && flushes_m < CMAX) flushes_m++;
            if (macc && !ack) begin
                if (pending < T) pending++;
                else begin pending = 0; err_m = 1; end
            end else begin
                pending = 0;
            end
        end
        #1;
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [31:0] r;
        logic [6:0]  op;
        r = $urandom();
        case ($urandom_range(0, 8))
            0: op = 7'b0000011;
            1: op = 7'b0100011;
            2: op = 7'b0110011;
            3: op = 7'b0010011;
            4: op = 7'b0110111;
            5: op = 7'b0010111;
            6: op = 7'b1101111;
            7: op = 7'b1100011;
            default: op = 7'b1100111;
        endcase
        return {r[31:25], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), r[14:12],
                5'($urandom_range(0, 3)), op};
    endfunction

    initial begin
        logic [31:0] mi;
        // Reset state
        step(1, NOP, NOP, 0, 0, 0);
        step(1, NOP, NOP, 0, 0, 0);

        // Forwarding of an ALU result to both operands
        step(0, 32'h0052_8333, 32'h0070_0293, 1, 0, 0);
        chk("fwd_both_a", 32'(fwd_a), 32'd1);

        // Load-use: exactly one bubble
        step(0, 32'h0002_8333, LW5, 1, 0, 1);
        step(0, 32'h0002_8333, NOP, 0, 0, 0);
        chk("lu_stalls", 32'(stall_cycles), 32'd1);

        // x0 destination never forwards
        step(0, 32'h0000_0333, 32'h0010_0013, 1, 0, 0);

        // Store with 3 wait cycles
        step(1, NOP, NOP, 0, 0, 0);
        repeat (3) step(0, NOP, SW5, 0, 0, 0);
        step(0, NOP, SW5, 0, 0, 1);
        chk("store_stalls", 32'(stall_cycles), 32'd3);

        // Timeout: frozen T cycles, released on the next, error sticky
        step(1, NOP, NOP, 0, 0, 0);
        repeat (T + 1) step(0, NOP, LW5, 0, 0, 0);
        step(0, NOP, NOP, 0, 0, 0);
        chk("timeout_err", 32'(mem_err), 32'd1);
        step(0, NOP, NOP, 0, 0, 0);
        step(1, NOP, NOP, 0, 0, 0);
        chk("err_cleared", 32'(mem_err), 32'd0);

        // Branch deferred through a 2-cycle wait
        repeat (2) step(0, NOP, SW5, 0, 1, 0);
        step(0, NOP, SW5, 0, 1, 1);
        chk("branch_flushes", 32'(flush_count), 32'd1);

        // Reset in the middle of a wait
        step(0, NOP, SW5, 0, 0, 0);
        step(1, NOP, SW5, 0, 0, 0);
        step(0, NOP, NOP, 0, 0, 0);

        // Randomized traffic; memory stage holds while the model is frozen
        mi = NOP;
        for (int i = 0; i < 600; i++) begin
            if (!frozen_m) mi = rnd_instr();
            step(($urandom_range(0, 60) == 0), rnd_instr(), mi, 1'($urandom()),
                 1'($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
